score_sequencer: RTL and testbench

Score sequencer upstream of the square-wave tone generator. Walks a note list held in an external synchronous ROM and holds each note's 4-bit middle/low pitch codes for its programmed duration. Emits a `beat` rising edge once per note, which the tone generator uses to latch `med`/`low`. Also drives an explicit mute (codes 0/0 plus a beat) when playback ends or is stopped, so the generator is left on the rest divisor.

---
 rtl/score_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_score_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_sequencer.sv
// score_sequencer
// Walks a note list in an external synchronous ROM and presents each note's
// middle/low pitch codes to the square-wave tone generator. Every note, and
// the final mute, is announced with a one-cycle beat strobe that rises one
// cycle after med/low settle. All outputs are registered.

module score_sequencer #(
    parameter int TICK_DIV = 1250000,  // clk_5m cycles per duration tick
    parameter int ADDR_W   = 8,        // score ROM address width
    parameter int LOOP     = 0         // 1: restart at address 0 on end marker
) (
    input  logic              clk_5m,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [3:0]        med,
    output logic [3:0]        low,
    output logic              beat,
    output logic              playing,
    output logic              done
);

    // A tick counter needs at least one bit even for TICK_DIV == 1.
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        READ,
        STROBE,
        SOUND,
        MUTE,
        MUTE_STROBE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          med_q, med_d;
    logic [3:0]          low_q, low_d;
    logic                beat_q, beat_d;
    logic                playing_q, playing_d;
    logic                done_q, done_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [3:0]          dur_cnt_q, dur_cnt_d;
    // Remembers that the current mute came from the end marker, so that the
    // done pulse is not raised for a user stop.
    logic                at_end_q, at_end_d;

    logic [3:0]          rom_dur;
    logic [3:0]          rom_med;
    logic [3:0]          rom_low;

    assign rom_dur = rom_data[11:8];
    assign rom_med = rom_data[7:4];
    assign rom_low = rom_data[3:0];

    // Next-state and next-output computation for the playback FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        med_d     = med_q;
        low_d     = low_q;
        beat_d    = beat_q;
        tick_d    = tick_q;
        dur_cnt_d = dur_cnt_q;
        at_end_d  = at_end_q;
        done_d    = 1'b0;

        if (stop && (state_q != IDLE)) begin
            // Stop has priority over start and always takes the mute path,
            // so the tone generator is left on the rest divisor.
            state_d  = MUTE;
            beat_d   = 1'b0;
            at_end_d = 1'b0;
        end else if (start) begin
            // Start from idle, or restart from anywhere, at the top of the score.
            state_d  = FETCH;
            addr_d   = '0;
            beat_d   = 1'b0;
            at_end_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_d = '0;
                end

                FETCH: begin
                    // ROM registers the address on this edge.
                    state_d = READ;
                end

                READ: begin
                    if (rom_dur != 4'd0) begin
                        med_d     = rom_med;
                        low_d     = rom_low;
                        dur_cnt_d = rom_dur;
                        tick_d    = '0;
                        state_d   = STROBE;
                    end else if (LOOP != 0) begin
                        addr_d  = '0;
                        state_d = FETCH;
                    end else begin
                        at_end_d = 1'b1;
                        state_d  = MUTE;
                    end
                end

                STROBE: begin
                    // med/low settled on the previous edge; latch them now.
                    beat_d  = 1'b1;
                    state_d = SOUND;
                end

                SOUND: begin
                    beat_d = 1'b0;
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (dur_cnt_q <= 4'd1) begin
                            // Address wraps naturally at 2^ADDR_W.
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = FETCH;
                        end else begin
                            dur_cnt_d = dur_cnt_q - 4'd1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end

                MUTE: begin
                    med_d   = 4'd0;
                    low_d   = 4'd0;
                    state_d = MUTE_STROBE;
                end

                MUTE_STROBE: begin
                    // First cycle raises beat; second drops it and goes idle.
                    if (!beat_q) begin
                        beat_d = 1'b1;
                    end else begin
                        beat_d   = 1'b0;
                        done_d   = at_end_q;
                        at_end_d = 1'b0;
                        addr_d   = '0;
                        state_d  = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    beat_d  = 1'b0;
                    addr_d  = '0;
                end
            endcase
        end

        playing_d = (state_d != IDLE);
    end

    // State and registered outputs; reset returns everything to silence.
    always_ff @(posedge clk_5m or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            med_q     <= 4'd0;
            low_q     <= 4'd0;
            beat_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            tick_q    <= '0;
            dur_cnt_q <= 4'd0;
            at_end_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            med_q     <= med_d;
            low_q     <= low_d;
            beat_q    <= beat_d;
            playing_q <= playing_d;
            done_q    <= done_d;
            tick_q    <= tick_d;
            dur_cnt_q <= dur_cnt_d;
            at_end_q  <= at_end_d;
        end
    end

    assign rom_addr = addr_q;
    assign med      = med_q;
    assign low      = low_q;
    assign beat     = beat_q;
    assign playing  = playing_q;
    assign done     = done_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Testbench for score_sequencer: three instances (stop at end, loop at end,
// 2-bit address with no end marker) share clock, reset, start and stop.

module tb_score_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;

    logic [7:0]  a0, a1;
    logic [1:0]  a2;
    logic [11:0] rd0, rd1, rd2;
    logic [3:0]  m0, m1, m2, l0, l1, l2;
    logic        b0, b1, b2, p0, p1, p2, d0, d1, d2;

    logic [11:0] rom0 [0:255];
    logic [11:0] rom2 [0:3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         e;
        int         dut;
        logic [7:0] addr;
        logic [3:0] med;
        logic [3:0] low;
        logic       beat;
        logic       play;
        logic       done;
    } vec_t;

    vec_t tbl [$];

    score_sequencer #(.TICK_DIV(4), .ADDR_W(8), .LOOP(0)) dut0 (
        .clk_5m(clk), .rst(rst), .start(start), .stop(stop),
        .rom_addr(a0), .rom_data(rd0), .med(m0), .low(l0),
        .beat(b0), .playing(p0), .done(d0)
    );

    score_sequencer #(.TICK_DIV(4), .ADDR_W(8), .LOOP(1)) dut1 (
        .clk_5m(clk), .rst(rst), .start(start), .stop(stop),
        .rom_addr(a1), .rom_data(rd1), .med(m1), .low(l1),
        .beat(b1), .playing(p1), .done(d1)
    );

    score_sequencer #(.TICK_DIV(4), .ADDR_W(2), .LOOP(0)) dut2 (
        .clk_5m(clk), .rst(rst), .start(start), .stop(stop),
        .rom_addr(a2), .rom_data(rd2), .med(m2), .low(l2),
        .beat(b2), .playing(p2), .done(d2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous score ROMs.
    always @(posedge clk) begin
        rd0 <= rom0[a0];
        rd1 <= rom0[a1];
        rd2 <= rom2[a2];
    end

    function automatic logic [18:0] snap(input int d);
        case (d)
            0:       return {a0, m0, l0, b0, p0, d0};
            1:       return {a1, m1, l1, b1, p1, d1};
            default: return {6'b0, a2, m2, l2, b2, p2, d2};
        endcase
    endfunction

    function automatic logic [18:0] ex(input logic [7:0] ad, input logic [3:0] m,
                                       input logic [3:0] l, input logic b,
                                       input logic p, input logic dn);
        return {ad, m, l, b, p, dn};
    endfunction

    task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {addr,med,low,beat,play,done}=%h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        step();
    endtask

    task automatic addv(input int e, input int d, input logic [7:0] ad, input logic [3:0] m,
                        input logic [3:0] l, input logic b, input logic p, input logic dn);
        vec_t v;
        v.e = e; v.dut = d; v.addr = ad; v.med = m; v.low = l;
        v.beat = b; v.play = p; v.done = dn;
        tbl.push_back(v);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 256; i++) rom0[i] = 12'h000;
        rom0[0] = 12'h210;
        rom0[1] = 12'h105;
        rom0[2] = 12'h000;
        rom2[0] = 12'h111;
        rom2[1] = 12'h122;
        rom2[2] = 12'h133;
        rom2[3] = 12'h144;

        // dut0: LOOP=0 full score
        addv(0,  0, 8'd0, 4'd0, 4'd0, 0, 1, 0);
        addv(1,  0, 8'd0, 4'd0, 4'd0, 0, 1, 0);
        addv(2,  0, 8'd0, 4'd1, 4'd0, 0, 1, 0);
        addv(3,  0, 8'd0, 4'd1, 4'd0, 1, 1, 0);
        addv(4,  0, 8'd0, 4'd1, 4'd0, 0, 1, 0);
        addv(10, 0, 8'd0, 4'd1, 4'd0, 0, 1, 0);
        addv(11, 0, 8'd1, 4'd1, 4'd0, 0, 1, 0);
        addv(12, 0, 8'd1, 4'd1, 4'd0, 0, 1, 0);
        addv(13, 0, 8'd1, 4'd0, 4'd5, 0, 1, 0);
        addv(14, 0, 8'd1, 4'd0, 4'd5, 1, 1, 0);
        addv(15, 0, 8'd1, 4'd0, 4'd5, 0, 1, 0);
        addv(18, 0, 8'd2, 4'd0, 4'd5, 0, 1, 0);
        addv(20, 0, 8'd2, 4'd0, 4'd5, 0, 1, 0);
        addv(21, 0, 8'd2, 4'd0, 4'd0, 0, 1, 0);
        addv(22, 0, 8'd2, 4'd0, 4'd0, 1, 1, 0);
        addv(23, 0, 8'd0, 4'd0, 4'd0, 0, 0, 1);
        addv(24, 0, 8'd0, 4'd0, 4'd0, 0, 0, 0);
        addv(30, 0, 8'd0, 4'd0, 4'd0, 0, 0, 0);
        // dut1: LOOP=1 restarts after the end marker
        addv(18, 1, 8'd2, 4'd0, 4'd5, 0, 1, 0);
        addv(20, 1, 8'd0, 4'd0, 4'd5, 0, 1, 0);
        addv(21, 1, 8'd0, 4'd0, 4'd5, 0, 1, 0);
        addv(22, 1, 8'd0, 4'd1, 4'd0, 0, 1, 0);
        addv(23, 1, 8'd0, 4'd1, 4'd0, 1, 1, 0);
        addv(24, 1, 8'd0, 4'd1, 4'd0, 0, 1, 0);
        // dut2: 2-bit address, every note dur=1, period 7 cycles
        addv(2,  2, 8'd0, 4'd1, 4'd1, 0, 1, 0);
        addv(3,  2, 8'd0, 4'd1, 4'd1, 1, 1, 0);
        addv(7,  2, 8'd1, 4'd1, 4'd1, 0, 1, 0);
        addv(9,  2, 8'd1, 4'd2, 4'd2, 0, 1, 0);
        addv(14, 2, 8'd2, 4'd2, 4'd2, 0, 1, 0);
        addv(16, 2, 8'd2, 4'd3, 4'd3, 0, 1, 0);
        addv(21, 2, 8'd3, 4'd3, 4'd3, 0, 1, 0);
        addv(23, 2, 8'd3, 4'd4, 4'd4, 0, 1, 0);
        addv(28, 2, 8'd0, 4'd4, 4'd4, 0, 1, 0);
        addv(30, 2, 8'd0, 4'd1, 4'd1, 0, 1, 0);
        addv(31, 2, 8'd0, 4'd1, 4'd1, 1, 1, 0);
        addv(35, 2, 8'd1, 4'd1, 4'd1, 0, 1, 0);

        do_reset();
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset_dut%0d", d), snap(d), ex(0, 0, 0, 0, 0, 0));

        // stop while idle is ignored
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_idle_a", snap(0), ex(0, 0, 0, 0, 0, 0));
        step();
        chk("stop_idle_b", snap(0), ex(0, 0, 0, 0, 0, 0));

        // table-driven main run
        pulse_start();
        for (int e = 0; e <= 36; e++) begin
            if (e > 0) step();
            foreach (tbl[i]) begin
                if (tbl[i].e == e)
                    chk($sformatf("vec%0d_e%0d_dut%0d", i, e, tbl[i].dut), snap(tbl[i].dut),
                        ex(tbl[i].addr, tbl[i].med, tbl[i].low, tbl[i].beat,
                           tbl[i].play, tbl[i].done));
            end
            chk($sformatf("loop_live_e%0d", e), {p1, d1}, 2'b10);
            chk($sformatf("wrap_live_e%0d", e), {p2, d2}, 2'b10);
        end

        // async reset mid-SOUND, then restart as from power-up
        do_reset();
        pulse_start();
        repeat (5) step();
        #2 rst = 1'b1;
        #1 chk("async_rst", snap(0), ex(0, 0, 0, 0, 0, 0));
        #1 rst = 1'b0;
        step();
        chk("post_rst_idle", snap(0), ex(0, 0, 0, 0, 0, 0));
        pulse_start();
        chk("post_rst_e0", snap(0), ex(0, 0, 0, 0, 1, 0));
        step();
        step();
        chk("post_rst_e2", snap(0), ex(0, 1, 0, 0, 1, 0));
        step();
        chk("post_rst_e3", snap(0), ex(0, 1, 0, 1, 1, 0));

        // stop during SOUND of note 0
        do_reset();
        pulse_start();
        repeat (5) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_e6", snap(0), ex(0, 1, 0, 0, 1, 0));
        step();
        chk("stop_e7", snap(0), ex(0, 0, 0, 0, 1, 0));
        step();
        chk("stop_e8", snap(0), ex(0, 0, 0, 1, 1, 0));
        step();
        chk("stop_e9", snap(0), ex(0, 0, 0, 0, 0, 0));
        step();
        chk("stop_e10", snap(0), ex(0, 0, 0, 0, 0, 0));

        // start during SOUND of note 1 restarts the score
        do_reset();
        pulse_start();
        repeat (15) step();
        chk("restart_e15", snap(0), ex(1, 0, 5, 0, 1, 0));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_e16", snap(0), ex(0, 0, 5, 0, 1, 0));
        step();
        chk("restart_e17", snap(0), ex(0, 0, 5, 0, 1, 0));
        step();
        chk("restart_e18", snap(0), ex(0, 1, 0, 0, 1, 0));
        step();
        chk("restart_e19", snap(0), ex(0, 1, 0, 1, 1, 0));

        // start and stop together: stop wins
        do_reset();
        pulse_start();
        repeat (5) step();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("both_e6", snap(0), ex(0, 1, 0, 0, 1, 0));
        step();
        chk("both_e7", snap(0), ex(0, 0, 0, 0, 1, 0));
        step();
        chk("both_e8", snap(0), ex(0, 0, 0, 1, 1, 0));
        step();
        chk("both_e9", snap(0), ex(0, 0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
